// File: rtl/digdug_pkg.sv
// Shared constants for the Dig Dug main-latch / interrupt controller slice.
// Holds the DEV bus decode addresses and the meaning of each main-latch bit.
package digdug_pkg;

    // DEV bus decode addresses
    localparam logic [15:0] ADDR_MAINLATCH = 16'h6820;  // 0x6820-0x6827, one bit per address
    localparam logic [15:0] ADDR_WDOG      = 16'h6830;  // watchdog kick, data ignored

    // Main-latch bit indices
    localparam int unsigned LB_IRQ0     = 0;  // CPU0 VBLANK IRQ enable
    localparam int unsigned LB_IRQ1     = 1;  // CPU1 VBLANK IRQ enable
    localparam int unsigned LB_NMI2_DIS = 2;  // CPU2 NMI disable (0 = enabled)
    localparam int unsigned LB_SUBRUN   = 3;  // CPU1/CPU2 run (0 = held in reset)

    // True when the bus address falls inside the 8-byte main-latch window.
    function automatic logic is_mainlatch(input logic [15:0] addr);
        return addr[15:3] == ADDR_MAINLATCH[15:3];
    endfunction

endpackage

// File: rtl/digdug_irq_ctrl_if.sv
// DEV bus / video timing / CPU control bundle for digdug_irq_ctrl.
//   master : drives DEV bus, VBLANK, VPOS, NMI0_REQ; observes the CPU control outputs
//   slave  : the controller; receives the bus and timing, drives RSTS/IRQS/NMIS/LATCH
// Signals:
//   DEV_AD[15:0]  bus address        DEV_WR    write strobe
//   DEV_DI[7:0]   write data (bit 0)  VBLANK    vertical blank level
//   VPOS[8:0]     current scanline   NMI0_REQ  NMI request for CPU0
//   RSTS[2:0]     per-CPU reset      IRQS[2:0] per-CPU IRQ level
//   NMIS[2:0]     per-CPU NMI level  LATCH[7:0] main-latch contents
interface digdug_irq_ctrl_if;

    logic [15:0] DEV_AD;
    logic        DEV_WR;
    logic [7:0]  DEV_DI;
    logic        VBLANK;
    logic [8:0]  VPOS;
    logic        NMI0_REQ;
    logic [2:0]  RSTS;
    logic [2:0]  IRQS;
    logic [2:0]  NMIS;
    logic [7:0]  LATCH;

    modport master (
        output DEV_AD, DEV_WR, DEV_DI, VBLANK, VPOS, NMI0_REQ,
        input  RSTS, IRQS, NMIS, LATCH
    );

    modport slave (
        input  DEV_AD, DEV_WR, DEV_DI, VBLANK, VPOS, NMI0_REQ,
        output RSTS, IRQS, NMIS, LATCH
    );

endinterface

// File: rtl/digdug_watchdog.sv
// Frame watchdog: counts VBLANK rising edges since the last kick and, once
// WDOG_FRAMES edges pass unkicked, holds WDRST high for RST_HOLD clocks.
// Ports:
//   CLK          DEV bus clock
//   RESET        asynchronous active-high reset
//   kick         single-cycle kick (write to the watchdog address)
//   vblank_rise  single-cycle VBLANK rising-edge strobe
//   WDRST        watchdog reset output (registered)
module digdug_watchdog #(
    parameter int unsigned WDOG_FRAMES = 8,   // 1..15
    parameter int unsigned RST_HOLD    = 64   // 1..127
) (
    input  logic CLK,
    input  logic RESET,
    input  logic kick,
    input  logic vblank_rise,
    output logic WDRST
);

    logic [3:0] frame_q, frame_d;
    logic [6:0] hold_q, hold_d;
    logic       wdrst_q, wdrst_d;

    always_comb begin
        frame_d = frame_q;
        hold_d  = hold_q;
        wdrst_d = wdrst_q;
        if (wdrst_q) begin
            // Kicks and frame edges are ignored for the whole hold window.
            if (hold_q == 7'(RST_HOLD - 1)) begin
                wdrst_d = 1'b0;
                hold_d  = '0;
                frame_d = '0;
            end else begin
                hold_d = hold_q + 7'd1;
            end
        end else if (kick) begin
            frame_d = '0;  // kick beats a coincident frame edge
        end else if (vblank_rise) begin
            if (frame_q == 4'(WDOG_FRAMES - 1)) begin
                wdrst_d = 1'b1;
                frame_d = '0;
            end else begin
                frame_d = frame_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_q <= '0;
            hold_q  <= '0;
            wdrst_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            hold_q  <= hold_d;
            wdrst_q <= wdrst_d;
        end
    end

    assign WDRST = wdrst_q;

endmodule

// File: rtl/digdug_irq_ctrl.sv
// Main-latch and interrupt/reset controller for the three Z80 cores.
// Decodes main-latch writes (0x6820-0x6827) and, when DIGDUG_WATCHDOG_EN is
// defined, watchdog kicks (0x6830). Produces per-CPU RSTS/IRQS/NMIS:
//   CPU0 IRQ on VBLANK rise (latch bit 0), CPU1 IRQ on VBLANK rise (bit 1),
//   CPU2 NMI on scanlines NMI_LINE_A/B (bit 2 disables), CPU1/2 run (bit 3).
// Ports:
//   CLK    DEV bus clock
//   RESET  asynchronous active-high reset
//   bus    digdug_irq_ctrl_if.slave (DEV bus, VBLANK, VPOS, NMI0_REQ in;
//          RSTS, IRQS, NMIS, LATCH out; all outputs registered)
// Build option: DIGDUG_WATCHDOG_EN adds the frame watchdog.
module digdug_irq_ctrl
    import digdug_pkg::*;
#(
    parameter int unsigned NMI_LINE_A  = 64,
    parameter int unsigned NMI_LINE_B  = 192,
    parameter int unsigned WDOG_FRAMES = 8,
    parameter int unsigned RST_HOLD    = 64
) (
    input  logic                     CLK,
    input  logic                     RESET,
    digdug_irq_ctrl_if.slave         bus
);

    logic [7:0] latch_q, latch_d;
    logic [1:0] irq_q, irq_d;
    logic [2:0] nmis_q, nmis_d;
    logic [2:0] rsts_q, rsts_d;
    logic       vblank_q;
    logic       vblank_rise_q, vblank_rise_d;
    logic       latch_wr;
    logic       nmi_line;
    logic       wdrst;
    logic       unused_di;

    assign unused_di = ^bus.DEV_DI[7:1];

    assign latch_wr = bus.DEV_WR && is_mainlatch(bus.DEV_AD);
    assign nmi_line = (bus.VPOS == 9'(NMI_LINE_A)) || (bus.VPOS == 9'(NMI_LINE_B));

    always_comb begin
        latch_d = latch_q;
        if (latch_wr) begin
            latch_d[bus.DEV_AD[2:0]] = bus.DEV_DI[0];
        end
        if (wdrst) begin
            latch_d = '0;
        end

        // Registered edge strobe: the IRQ lands one clock after the edge is seen.
        vblank_rise_d = bus.VBLANK & ~vblank_q;

        // Gating by the next latch value makes a clearing write both the
        // acknowledge and the winner over a coincident edge.
        irq_d[0] = latch_d[LB_IRQ0] & (irq_q[0] | (vblank_rise_q & latch_q[LB_IRQ0]));
        irq_d[1] = latch_d[LB_IRQ1] & (irq_q[1] | (vblank_rise_q & latch_q[LB_IRQ1]));

        nmis_d = {nmi_line & ~latch_q[LB_NMI2_DIS] & ~rsts_q[2], 1'b0, bus.NMI0_REQ};

        rsts_d = {{2{~latch_d[LB_SUBRUN] | wdrst}}, wdrst};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            latch_q       <= '0;
            irq_q         <= '0;
            nmis_q        <= '0;
            rsts_q        <= 3'b111;
            vblank_q      <= 1'b0;
            vblank_rise_q <= 1'b0;
        end else begin
            latch_q       <= latch_d;
            irq_q         <= irq_d;
            nmis_q        <= nmis_d;
            rsts_q        <= rsts_d;
            vblank_q      <= bus.VBLANK;
            vblank_rise_q <= vblank_rise_d;
        end
    end

`ifdef DIGDUG_WATCHDOG_EN
    logic kick;
    assign kick = bus.DEV_WR && (bus.DEV_AD == ADDR_WDOG);

    digdug_watchdog #(
        .WDOG_FRAMES (WDOG_FRAMES),
        .RST_HOLD    (RST_HOLD)
    ) u_watchdog (
        .CLK         (CLK),
        .RESET       (RESET),
        .kick        (kick),
        .vblank_rise (vblank_rise_q),
        .WDRST       (wdrst)
    );
`else
    assign wdrst = 1'b0;
    localparam int unsigned unused_wdog_cfg = WDOG_FRAMES + RST_HOLD;
`endif

    assign bus.LATCH = latch_q;
    assign bus.IRQS  = {1'b0, irq_q};
    assign bus.NMIS  = nmis_q;
    assign bus.RSTS  = rsts_q;

endmodule

// File: tb/tb_digdug_irq_ctrl.sv
// Bench for digdug_irq_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a frame/event-level reference model.
module tb_digdug_irq_ctrl;

`ifdef DIGDUG_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam int WDOG_FRAMES = 8;
    localparam int RST_HOLD    = 64;

    logic CLK = 1'b0;
    logic RESET;
    always #10 CLK = ~CLK;

    digdug_irq_ctrl_if bus ();

    digdug_irq_ctrl #(
        .NMI_LINE_A  (64),
        .NMI_LINE_B  (192),
        .WDOG_FRAMES (WDOG_FRAMES),
        .RST_HOLD    (RST_HOLD)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cnt_rst_all = 0;  // cycles with RSTS == 3'b111
    int cnt_rst0    = 0;  // cycles with RSTS[0] == 1

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: state as seen by software and by the CPUs.
    bit [7:0] m_latch;
    bit [1:0] m_irq;
    bit [2:0] m_nmi;
    bit [2:0] m_rsts;
    bit       m_vb1, m_vb2;      // VBLANK as sampled one and two clocks ago
    int       m_frames;          // frames since last kick
    int       m_hold_left;       // remaining watchdog-reset clocks

    task automatic model_reset();
        m_latch = '0; m_irq = '0; m_nmi = '0; m_rsts = 3'b111;
        m_vb1 = 1'b0; m_vb2 = 1'b0; m_frames = 0; m_hold_left = 0;
    endtask

    task automatic model_step();
        bit       in_wd = (m_hold_left != 0);
        bit       rise  = m_vb1 && !m_vb2;
        bit [7:0] nl    = m_latch;
        bit       kick  = bus.DEV_WR && (bus.DEV_AD == 16'h6830);
        bit       line  = (bus.VPOS == 9'd64) || (bus.VPOS == 9'd192);
        int       idx;
        if (bus.DEV_WR && bus.DEV_AD >= 16'h6820 && bus.DEV_AD <= 16'h6827) begin
            idx = int'(bus.DEV_AD) - 'h6820;
            nl[idx] = bus.DEV_DI[0];
        end
        if (in_wd) nl = '0;
        for (int n = 0; n < 2; n++)
            m_irq[n] = nl[n] && (m_irq[n] || (rise && m_latch[n]));
        m_nmi  = {line && !m_latch[2] && !m_rsts[2], 1'b0, bus.NMI0_REQ};
        m_rsts = {!nl[3] || in_wd, !nl[3] || in_wd, in_wd};
        if (WD_EN) begin
            if (in_wd) begin
                m_hold_left--;
                if (m_hold_left == 0) m_frames = 0;
            end else if (kick) begin
                m_frames = 0;
            end else if (rise) begin
                m_frames++;
                if (m_frames == WDOG_FRAMES) begin
                    m_hold_left = RST_HOLD;
                    m_frames = 0;
                end
            end
        end
        m_latch = nl;
        m_vb2 = m_vb1;
        m_vb1 = bus.VBLANK;
    endtask

    // One clock: returns at the following negedge, where inputs are driven.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("LATCH", 32'(bus.LATCH), 32'(m_latch));
        check("IRQS",  32'(bus.IRQS),  32'({1'b0, m_irq}));
        check("NMIS",  32'(bus.NMIS),  32'(m_nmi));
        check("RSTS",  32'(bus.RSTS),  32'(m_rsts));
        if (bus.RSTS == 3'b111) cnt_rst_all++;
        if (bus.RSTS[0]) cnt_rst0++;
        @(negedge CLK);
    endtask

    task automatic wr(input logic [15:0] ad, input logic [7:0] di);
        bus.DEV_AD = ad; bus.DEV_DI = di; bus.DEV_WR = 1'b1;
        tick();
        bus.DEV_WR = 1'b0;
    endtask

    task automatic frame(input bit do_kick);
        bus.VBLANK = 1'b1;
        repeat (4) tick();
        bus.VBLANK = 1'b0;
        repeat (8) tick();
        if (do_kick) wr(16'h6830, 8'h00);
    endtask

    int vb_len;

    initial begin
        bus.DEV_AD = '0; bus.DEV_WR = 1'b0; bus.DEV_DI = '0;
        bus.VBLANK = 1'b0; bus.VPOS = '0; bus.NMI0_REQ = 1'b0;
        RESET = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_rsts",  32'(bus.RSTS),  32'h7);
        check("rst_latch", 32'(bus.LATCH), 32'h0);
        check("rst_irqs",  32'(bus.IRQS),  32'h0);
        check("rst_nmis",  32'(bus.NMIS),  32'h0);
        RESET = 1'b0;
        tick();
        check("rel_rsts",  32'(bus.RSTS),  32'h6);
        check("rel_irqs",  32'(bus.IRQS),  32'h0);
        check("rel_latch", 32'(bus.LATCH), 32'h0);

        // CPU1/CPU2 run bit
        wr(16'h6823, 8'h01);
        check("run_on",  32'(bus.RSTS), 32'h0);
        wr(16'h6823, 8'h00);
        check("run_off", 32'(bus.RSTS), 32'h6);
        wr(16'h6823, 8'h01);

        // IRQ0: raise, acknowledge, edge vs clear on the same clock
        wr(16'h6820, 8'h01);
        bus.VBLANK = 1'b1;
        tick();
        check("irq0_lat1", 32'(bus.IRQS[0]), 32'h0);
        tick();
        check("irq0_set", 32'(bus.IRQS[0]), 32'h1);
        repeat (2) tick();
        bus.VBLANK = 1'b0;
        repeat (2) tick();
        wr(16'h6820, 8'h00);
        check("irq0_ack", 32'(bus.IRQS[0]), 32'h0);
        wr(16'h6820, 8'h01);
        repeat (2) tick();
        bus.VBLANK = 1'b1;
        tick();
        wr(16'h6820, 8'h00);  // clear lands on the clock that would raise the IRQ
        check("irq0_clrwin", 32'(bus.IRQS[0]), 32'h0);
        tick();
        check("irq0_clrwin2", 32'(bus.IRQS[0]), 32'h0);
        // enable while VBLANK is already high: no IRQ until the next edge
        wr(16'h6820, 8'h01);
        repeat (3) tick();
        check("irq0_nolvl", 32'(bus.IRQS[0]), 32'h0);
        bus.VBLANK = 1'b0;
        repeat (2) tick();
        wr(16'h6820, 8'h00);

        // CPU2 NMI line sweep
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < 264; v++) begin
                bus.VPOS = 9'(v);
                tick();
                if (v >= 62 && v <= 66 || v >= 190 && v <= 194)
                    check("nmi2", 32'(bus.NMIS[2]),
                          32'((pass == 0) && (v == 64 || v == 192)));
            end
            if (pass == 0) wr(16'h6822, 8'h01);
        end
        wr(16'h6822, 8'h00);

        // Watchdog: eight unkicked frames
        wr(16'h6830, 8'h00);
        cnt_rst_all = 0;
        for (int f = 0; f < 8; f++) frame(1'b0);
        repeat (80) tick();
        check("wd_hold", 32'(cnt_rst_all), WD_EN ? 32'd64 : 32'd0);
        check("wd_latch3", 32'(bus.LATCH[3]), WD_EN ? 32'h0 : 32'h1);
        // Kicking every 7 frames keeps CPU0 out of reset
        wr(16'h6823, 8'h01);
        wr(16'h6830, 8'h00);
        cnt_rst0 = 0;
        for (int f = 1; f <= 30; f++) frame(f % 7 == 0);
        check("wd_kicked", 32'(cnt_rst0), 32'd0);

        // Randomized traffic
        vb_len = 5;
        for (int c = 0; c < 2500; c++) begin
            if (--vb_len <= 0) begin
                bus.VBLANK = ~bus.VBLANK;
                vb_len = int'($urandom_range(1, 20));
            end
            case ($urandom_range(0, 5))
                0: bus.VPOS = 9'd64;
                1: bus.VPOS = 9'd192;
                2: bus.VPOS = 9'(63 + $urandom_range(0, 2));
                default: bus.VPOS = 9'($urandom_range(0, 263));
            endcase
            bus.NMI0_REQ = 1'($urandom_range(0, 1));
            bus.DEV_DI = 8'($urandom);
            bus.DEV_WR = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 19))
                0: bus.DEV_AD = 16'h6830;
                1: bus.DEV_AD = 16'($urandom);
                2: bus.DEV_AD = 16'h6828;
                default: bus.DEV_AD = 16'h6820 + 16'($urandom_range(0, 7));
            endcase
            tick();
        end
        bus.DEV_WR = 1'b0;
        bus.VBLANK = 1'b0;
        repeat (RST_HOLD + 4) tick();

        // Async reset mid-operation with IRQ1 pending
        wr(16'h6823, 8'h01);
        wr(16'h6821, 8'h01);
        bus.VPOS = 9'd64;
        repeat (3) tick();
        bus.VBLANK = 1'b1;
        repeat (2) tick();
        check("irq1_pend", 32'(bus.IRQS[1]), 32'h1);
        #2;
        RESET = 1'b1;
        #1;
        check("async_irqs",  32'(bus.IRQS),  32'h0);
        check("async_latch", 32'(bus.LATCH), 32'h0);
        check("async_nmis",  32'(bus.NMIS),  32'h0);
        check("async_rsts",  32'(bus.RSTS),  32'h7);
        model_reset();
        bus.VBLANK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        check("rerel_rsts", 32'(bus.RSTS), 32'h6);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
